// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic phase controller.
package tl_pkg;

  localparam int unsigned CNT_W = 5;

  localparam int unsigned DEF_T_RED    = 24;
  localparam int unsigned DEF_T_GREEN  = 20;
  localparam int unsigned DEF_T_YELLOW = 3;
  localparam int unsigned DEF_T_SHORT  = 5;

  // Code 2'd3 is unused and recovers to ST_RED.
  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

endpackage

// File: rtl/phase_timer.sv
// Reloadable down-counter shared by all light phases; load wins over decrement.
module phase_timer
  import tl_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] q,
  output logic             zero
);

  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q - CNT_W'(1);
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// RED -> GREEN -> YELLOW sequencer with pedestrian request latch and GREEN shortening.
module traffic_phase_ctrl
  import tl_pkg::*;
#(
  parameter int unsigned T_RED    = DEF_T_RED,
  parameter int unsigned T_GREEN  = DEF_T_GREEN,
  parameter int unsigned T_YELLOW = DEF_T_YELLOW,
  parameter int unsigned T_SHORT  = DEF_T_SHORT
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             en,
  input  logic             ped_req,
  output logic             red,
  output logic             yellow,
  output logic             green,
  output logic             walk,
  output logic [CNT_W-1:0] remain,
  output logic             phase_start
);

  localparam logic [CNT_W-1:0] LD_RED    = CNT_W'(T_RED - 1);
  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_SHORT  = CNT_W'(T_SHORT - 1);

  state_t           state;
  state_t           next_c;
  logic             ped_pend;
  logic             zero;
  logic             illegal_c;
  logic             shorten_c;
  logic             load_c;
  logic [CNT_W-1:0] dur_c;
  logic [CNT_W-1:0] load_val_c;

  phase_timer #(
    .RST_VAL (LD_RED)
  ) u_timer (
    .ck       (ck),
    .rs       (rs),
    .en       (en),
    .load     (load_c),
    .load_val (load_val_c),
    .q        (remain),
    .zero     (zero)
  );

  // Next phase, counter reload decision and reload value.
  always_comb begin
    next_c     = ST_RED;
    illegal_c  = 1'b0;
    dur_c      = LD_RED;
    shorten_c  = 1'b0;
    load_c     = 1'b0;
    load_val_c = LD_SHORT;

    case (state)
      ST_RED:    next_c = ST_GREEN;
      ST_GREEN:  next_c = ST_YELLOW;
      ST_YELLOW: next_c = ST_RED;
      default: begin
        next_c    = ST_RED;
        illegal_c = 1'b1;
      end
    endcase

    case (next_c)
      ST_GREEN:  dur_c = LD_GREEN;
      ST_YELLOW: dur_c = LD_YELLOW;
      default:   dur_c = LD_RED;
    endcase

    shorten_c = (state == ST_GREEN) && (ped_pend || ped_req) && (remain > LD_SHORT);
    load_c    = illegal_c || (en && (zero || shorten_c));
    if (illegal_c || zero) begin
      load_val_c = dur_c;
    end
  end

  // Phase register, pedestrian latch and walk lamp.
  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      state       <= ST_RED;
      walk        <= 1'b0;
      ped_pend    <= 1'b0;
      phase_start <= 1'b0;
    end else begin
      phase_start <= 1'b0;
      ped_pend    <= ped_pend | ped_req;
      if (illegal_c) begin
        state <= ST_RED;
        walk  <= 1'b0;
      end else if (en && zero) begin
        state       <= next_c;
        phase_start <= 1'b1;
        if (next_c == ST_RED) begin
          // A request on the entering edge is served now, not re-latched.
          walk     <= ped_pend | ped_req;
          ped_pend <= 1'b0;
        end else begin
          walk <= 1'b0;
        end
      end
    end
  end

  assign green  = (state == ST_GREEN);
  assign yellow = (state == ST_YELLOW);
  assign red    = ~(green | yellow);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed vector bench for traffic_phase_ctrl at default parameters.
module tb_traffic_phase_ctrl;

  logic       ck;
  logic       rs;
  logic       en;
  logic       ped_req;
  logic       red;
  logic       yellow;
  logic       green;
  logic       walk;
  logic [4:0] remain;
  logic       phase_start;

  int tests  = 0;
  int failed = 0;
  int ps_cnt = 0;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  typedef struct {
    int unsigned clocks;
    logic        en;
    logic        ped;
    logic [2:0]  lamps;
    logic        walk;
    logic [4:0]  remain;
    logic        ps;
  } vec_t;

  vec_t vecs[$];

  traffic_phase_ctrl dut (
    .ck          (ck),
    .rs          (rs),
    .en          (en),
    .ped_req     (ped_req),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .walk        (walk),
    .remain      (remain),
    .phase_start (phase_start)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  always @(negedge ck) begin
    if (phase_start) ps_cnt++;
  end

  task automatic check(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, got, exp);
    end
  endtask

  task automatic check_outputs(input int row, input logic [2:0] lamps, input logic w,
                               input logic [4:0] rem, input logic ps);
    check("lamps", row, 32'({red, yellow, green}), 32'(lamps));
    check("walk", row, 32'(walk), 32'(w));
    check("remain", row, 32'(remain), 32'(rem));
    check("phase_start", row, 32'(phase_start), 32'(ps));
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  function automatic void add(input int unsigned c, input logic e, input logic p,
                              input logic [2:0] l, input logic w, input logic [4:0] r, input logic ps);
    vec_t v;
    v.clocks = c; v.en = e; v.ped = p; v.lamps = l; v.walk = w; v.remain = r; v.ps = ps;
    vecs.push_back(v);
  endfunction

  initial begin
    rs = 1'b1; en = 1'b1; ped_req = 1'b0;

    // Asynchronous reset, observed before any clock edge.
    #1 rs = 1'b0;
    #1 check_outputs(-1, R, 1'b0, 5'd23, 1'b0);
    #6 rs = 1'b1;

    // Full cycle with no requests.
    add(1,  1, 0, R, 0, 22, 0);
    add(22, 1, 0, R, 0, 0,  0);
    add(1,  1, 0, G, 0, 19, 1);
    add(1,  1, 0, G, 0, 18, 0);
    add(18, 1, 0, G, 0, 0,  0);
    add(1,  1, 0, Y, 0, 2,  1);
    add(2,  1, 0, Y, 0, 0,  0);
    add(1,  1, 0, R, 0, 23, 1);
    // Request shortens GREEN, walk served in the next RED.
    add(23, 1, 0, R, 0, 0,  0);
    add(1,  1, 0, G, 0, 19, 1);
    add(4,  1, 0, G, 0, 15, 0);
    add(1,  1, 1, G, 0, 4,  0);
    add(4,  1, 0, G, 0, 0,  0);
    add(1,  1, 0, Y, 0, 2,  1);
    add(3,  1, 0, R, 1, 23, 1);
    add(23, 1, 0, R, 1, 0,  0);
    add(1,  1, 0, G, 0, 19, 1);
    add(5,  1, 0, G, 0, 14, 0);
    // Request too late to shorten.
    add(11, 1, 0, G, 0, 3,  0);
    add(1,  1, 1, G, 0, 2,  0);
    add(2,  1, 0, G, 0, 0,  0);
    add(1,  1, 0, Y, 0, 2,  1);
    add(3,  1, 0, R, 1, 23, 1);
    add(24, 1, 0, G, 0, 19, 1);
    add(20, 1, 0, Y, 0, 2,  1);
    add(1,  1, 0, Y, 0, 1,  0);
    // Enable low mid-YELLOW; request still latched.
    add(3,  0, 1, Y, 0, 1,  0);
    add(7,  0, 0, Y, 0, 1,  0);
    add(1,  1, 0, Y, 0, 0,  0);
    add(2,  0, 0, Y, 0, 0,  0);
    add(1,  1, 0, R, 1, 23, 1);
    add(1,  1, 0, R, 1, 22, 0);
    // Set up a YELLOW with a pending request.
    add(22, 1, 0, R, 1, 0,  0);
    add(1,  1, 0, G, 0, 19, 1);
    add(1,  1, 1, G, 0, 4,  0);
    add(5,  1, 0, Y, 0, 2,  1);

    ps_cnt = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      en      = vecs[i].en;
      ped_req = vecs[i].ped;
      step(vecs[i].clocks);
      check_outputs(i, vecs[i].lamps, vecs[i].walk, vecs[i].remain, vecs[i].ps);
      if (i == 8) check("ps_count", i, 32'(ps_cnt), 32'd3);
    end

    // Reset mid-YELLOW with a pending request, away from the clock edge.
    en = 1'b1; ped_req = 1'b0;
    #3 rs = 1'b0;
    #1 check_outputs(100, R, 1'b0, 5'd23, 1'b0);
    #3 rs = 1'b1;
    ped_req = 1'b1;
    step(1);
    check_outputs(101, R, 1'b0, 5'd22, 1'b0);
    ped_req = 1'b0;
    step(22);
    check_outputs(102, R, 1'b0, 5'd0, 1'b0);
    step(1);
    check_outputs(103, G, 1'b0, 5'd19, 1'b1);
    // Request latched during RED caps the following GREEN.
    step(1);
    check_outputs(104, G, 1'b0, 5'd4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Sequencer for a single-intersection signal head, built around one reloadable 5-bit down-counter that is shared by all three light phases. The controller steps RED → GREEN → YELLOW → RED, reloads the counter with each phase's duration, and shortens GREEN when a pedestrian request is pending. It sits between the board's button/enable inputs and the lamp and 7-segment "time remaining" outputs.

## Interface
- T_RED, default 24: RED duration in enabled cycles (1..31).
- T_GREEN, default 20: nominal GREEN duration (1..31).
- T_YELLOW, default 3: YELLOW duration (1..31).
- T_SHORT, default 5: GREEN remaining-time cap once a pedestrian request is pending (1..T_GREEN).
- ck, input, 1: the only clock; all state updates on the rising edge.
- rs, input, 1: reset, asynchronous, active-low.
- en, input, 1: count enable (tick). When 0, phase and counter hold.
- ped_req, input, 1: pedestrian button. Level is sampled each clock; no debounce inside this block.
- red / yellow / green, output, 1 each: lamp drives. Exactly one is high at all times.
- walk, output, 1: pedestrian WALK lamp. Only ever high during RED.
- remain, output, 5: counter value. Phase ends after the cycle in which it reads 0.
- phase_start, output, 1: registered one-cycle pulse in the first cycle of each new phase.

## Operation
- **States:** RED, GREEN, YELLOW. Encoding is 2 bits; the fourth code recovers to RED with remain = T_RED-1 on the next edge.
- **Reset (rs=0):** the following take effect immediately, without waiting for a clock edge:
  - state = RED, remain = T_RED-1, walk = 0, ped_pend = 0, phase_start = 0.
- **Each edge with rs=1 and en=1:**
  - If remain == 0: go to the next state and load remain with D_next-1. D_next is T_GREEN, T_YELLOW or T_RED. Set phase_start = 1.
  - Else, if state == GREEN, (ped_pend | ped_req) is set, and remain > T_SHORT-1: load remain = T_SHORT-1 (no decrement that cycle).
  - Else: remain = remain - 1.
  - Result: each phase lasts exactly its duration D in enabled cycles, with remain counting D-1 down to 0.
- **Pedestrian latch:**
  - ped_pend is set by ped_req on any edge, regardless of en.
  - On the edge that enters RED: walk = ped_pend | ped_req, and ped_pend clears. That same-edge request is served by this RED and is not re-latched.
  - ped_req arriving during RED is latched for the next cycle and does not raise walk in the current RED.
  - walk clears on the edge that leaves RED.
- **en=0:** state, remain and walk hold; phase_start = 0; ped_pend can still be set.
- **Lamps:** decoded combinationally from state only. There is no all-off state.

## Timing
- phase_start is high only in the cycle after a transition edge. It is low whenever en was 0 at the preceding edge.
- **Latency from request to shortened GREEN:** zero edges. The request is sampled and remain is capped at the same edge, provided en=1.
- With all defaults and en held at 1, the full cycle is 24 + 20 + 3 = 47 clocks.
- No arithmetic wrap: remain never decrements below 0, because the reload takes priority.
- A mid-phase reset returns to RED with remain = 23 (at defaults) asynchronously. After release, counting resumes on the first edge where rs=1.

## Structure
- **Shared package (tl_pkg):**
  - State encoding constants ST_RED, ST_GREEN, ST_YELLOW.
  - The 5-bit counter width constant.
  - Default durations.
- **Sub-module phase_timer:** the 5-bit loadable down-counter.
  - Ports: ck, rs, en, load, load_val, q, zero.
  - Reset value is a parameter.
- The controller FSM, pedestrian latch and output decode live in traffic_phase_ctrl.

## Test plan
All scenarios use default parameters.
- **Reset and first transition:** rs=0 then released, en=1 → red=1, remain=23, walk=0. After 24 clocks: green=1, remain=19, phase_start high for 1 cycle.
- **Full cycle with no requests:** 47 enabled clocks → back to red=1, remain=23. phase_start has pulsed exactly 3 times.
- **Request shortens GREEN:** ped_req sampled while GREEN with remain=15 → after that edge remain=4; YELLOW follows 5 clocks later. Entering RED raises walk=1 for 24 cycles, then ped_pend=0.
- **Request too late to shorten:** ped_req while GREEN with remain=3 → remain=2 next edge (no reload). walk=1 in the following RED.
- **Enable low:** en=0 for 10 clocks mid-YELLOW with remain=1 → state and remain unchanged, phase_start=0. A ped_req during the hold is still latched.
- **Reset mid-phase:** rs dropped mid-YELLOW with walk pending → red=1, remain=23, walk=0 asynchronously, before the next ck edge.
